// File: rtl/i2s_tx_pkg.sv
// Shared types and parameter helpers for the I2S sample transmitter.
package i2s_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int frame_bits(input int slot_width);
        return 2 * slot_width;
    endfunction

    function automatic int cnt_width(input int slot_width);
        return $clog2(2 * slot_width);
    endfunction

    function automatic int div_width(input int bclk_div);
        return (bclk_div > 1) ? $clog2(bclk_div) : 1;
    endfunction

    function automatic bit params_ok(input int dw, input int sw, input int div);
        return (dw >= 1) && (dw <= sw) && (div >= 1);
    endfunction

endpackage

// File: rtl/i2s_sample_tx_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV cycles and strobes
// fall_evt in the cycle whose closing edge drives bclk from 1 to 0.
import i2s_tx_pkg::*;

module i2s_bclk_gen #(
    parameter int BCLK_DIV = 2
) (
    input  logic CLK,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic fall_evt
);

    localparam int DW = div_width(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tc;

    assign tc       = (div_cnt == DIV_LAST);
    assign fall_evt = en && tc && bclk;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// Mono-to-stereo I2S serializer with a one-deep holding register.
// Define I2S_TX_UNDERRUN_HOLD_EN to repeat the last real sample on underrun.
import i2s_tx_pkg::*;

module i2s_sample_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int FRAME_BITS = frame_bits(SLOT_WIDTH);
    localparam int CW         = cnt_width(SLOT_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] SLOT_B   = CW'(SLOT_WIDTH);

    if (!params_ok(DATA_WIDTH, SLOT_WIDTH, BCLK_DIV)) begin : g_bad_params
        $error("i2s_sample_tx: illegal DATA_WIDTH/SLOT_WIDTH/BCLK_DIV");
    end

    function automatic logic [SLOT_WIDTH-1:0] pad_slot(
        input logic [DATA_WIDTH-1:0] s
    );
        return SLOT_WIDTH'(s) << (SLOT_WIDTH - DATA_WIDTH);
    endfunction

    state_t                  state_q, state_d;
    logic                    fall_evt;
    logic [CW-1:0]           bit_cnt, bit_nxt;
    logic                    full_q;
    logic [DATA_WIDTH-1:0]   hold_q, frame_q;
    logic [DATA_WIDTH-1:0]   load_val, fill_val;
    logic [SLOT_WIDTH-1:0]   shift_q;
    logic                    accept;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk (
        .CLK      (CLK),
        .rst      (rst),
        .en       (en),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    logic [DATA_WIDTH-1:0] last_sample;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            last_sample <= '0;
        end else if (frame_start && full_q) begin
            last_sample <= hold_q;
        end
    end

    assign fill_val = last_sample;
`else
    assign fill_val = '0;
`endif

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = en ? RUN : IDLE;
        x_ready     = (state_q == RUN) && !full_q;
        accept      = x_valid && x_ready;
        frame_start = fall_evt && (bit_cnt == LAST_BIT);
        underrun    = frame_start && !full_q;
        bit_nxt     = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        load_val    = full_q ? hold_q : fill_val;
    end

    // The shift register reloads at both slot starts, so sdata lags
    // bit_cnt by one position as I2S requires.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            bit_cnt <= LAST_BIT;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
            full_q  <= 1'b0;
            hold_q  <= '0;
            frame_q <= '0;
            shift_q <= '0;
        end else if (!en) begin
            bit_cnt <= LAST_BIT;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
            full_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                lrclk   <= (bit_nxt >= SLOT_B);
                sdata   <= shift_q[SLOT_WIDTH-1];
                if (frame_start)
                    shift_q <= pad_slot(load_val);
                else if (bit_nxt == SLOT_B)
                    shift_q <= pad_slot(frame_q);
                else
                    shift_q <= shift_q << 1;
            end
            if (frame_start) begin
                frame_q <= load_val;
                full_q  <= 1'b0;
            end
            if (accept) begin
                hold_q <= x;
                full_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
- Output end of the effect chain: takes processed samples (the `y` stream of the delay and other effect stages) through a valid/ready handshake.
- Serializes each sample as a standard I2S frame (bclk, lrclk, sdata) toward the board DAC.
- Mono source: each accepted sample is sent in both the left and right slots.
- Bit clock is derived from CLK; all logic runs in the single CLK domain.

Parameters:
- DATA_WIDTH, 32, sample width in bits; must satisfy DATA_WIDTH <= SLOT_WIDTH.
- SLOT_WIDTH, 32, bits per channel slot on the serial line.
- BCLK_DIV, 2, CLK cycles per bclk half-period; must be >= 1.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  synchronous run enable.
- x  in  DATA_WIDTH  sample to transmit, two's complement.
- x_valid  in  1  x holds a sample.
- x_ready  out  1  holding register empty; sample accepted when x_valid && x_ready.
- bclk  out  1  serial bit clock.
- lrclk  out  1  word select; 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first; changes only on bclk falling edges.
- frame_start  out  1  one-CLK pulse when a new frame's sample is loaded.
- underrun  out  1  one-CLK pulse when a frame starts with the holding register empty.

Behaviour:
- Reset (rst=0, async):
  - bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0.
  - Holding register empty, x_ready=0; div_cnt=0; bit_cnt=2*SLOT_WIDTH-1.
  - Shift register and last_sample cleared to 0.
- States: IDLE (en=0) and RUN (en=1).
- IDLE:
  - Counters, bclk, lrclk and sdata forced to their reset values.
  - Holding register flushed; x_ready=0.
  - Entered on the first CLK edge with en=0, including mid-frame (frame abandoned, no underrun).
- RUN:
  - x_ready = holding register empty.
  - div_cnt counts 0..BCLK_DIV-1; at terminal count it wraps and bclk toggles.
  - Falling-edge event = toggle from 1 to 0. At each falling-edge event, bit_cnt increments modulo 2*SLOT_WIDTH.
  - lrclk = (bit_cnt >= SLOT_WIDTH), updated on the same edge.
- Frame start = falling-edge event where bit_cnt wraps to 0:
  - Holding contents loaded into the frame register and frame_start pulses.
  - Holding register marked empty.
  - If holding was empty: underrun pulses and a zero sample is used.
  - First frame_start occurs 2*BCLK_DIV CLK cycles after entering RUN.
- sdata for the bit_cnt value b reached on a falling edge (I2S one-bit delay):
  - w = (b-1) mod 2*SLOT_WIDTH; k = w mod SLOT_WIDTH.
  - sdata = sample[DATA_WIDTH-1-k] if k < DATA_WIDTH, else 0 (trailing zero pad).
  - The MSB of the left slot therefore appears at b=1.
  - At b=0, sdata carries the last right-slot bit of the previous frame.
- Frame length = 4*SLOT_WIDTH*BCLK_DIV CLK cycles (256 at defaults).
- Simultaneous accept and frame-start load in the same cycle:
  - The load sees the pre-accept holding state. If holding was empty, underrun is flagged and the accepted sample fills holding for the next frame.
  - If holding was full, the load empties holding, but x_ready was 0 that cycle, so no accept occurs.
- Holding depth is 1. A producer holding x_valid high with no new data is stalled by x_ready; samples are never overwritten.

Optional Feature:
- Macro I2S_TX_UNDERRUN_HOLD_EN.
- Defined: an underrun frame retransmits last_sample, the most recently loaded real sample. last_sample is updated at every non-underrun load. The underrun pulse is unchanged.
- Undefined: an underrun frame transmits zeros and the last_sample register is not built.

Decomposition:
- Package i2s_tx_pkg:
  - State encoding IDLE/RUN.
  - Localparam FRAME_BITS = 2*SLOT_WIDTH.
  - bit_cnt width = clog2(FRAME_BITS).
  - Parameter-legality checks.
- Sub-module i2s_bclk_gen:
  - Contains div_cnt and bclk.
  - Outputs a one-cycle fall_evt strobe used by the top-level frame logic.

Test Plan:
- Reset release, en=1, no input -> first frame_start and underrun at cycle 4 after release; sdata stays 0 for the whole frame; lrclk period 256 CLK cycles.
- x=32'h8000_0001 presented before the first frame -> left slot sdata = 1, then 30 zeros, then 1 (MSB at b=1), right slot identical; x_ready returns high the cycle after frame_start.
- Continuous x_valid with incrementing samples 1,2,3 -> one sample consumed per frame, no underrun, x_ready low between accepts, serialized values match in order.
- x_valid asserted in the exact frame_start cycle with holding empty -> underrun pulses, and that sample appears in the following frame.
- en dropped mid-left-slot then raised after 10 cycles -> outputs 0 during IDLE, holding flushed, frame restarts with frame_start 4 cycles after en rises; async rst mid-frame zeroes outputs immediately.
- With I2S_TX_UNDERRUN_HOLD_EN: send 32'h1234_5678, then starve -> next frame repeats 32'h1234_5678 with underrun pulse; without the macro the next frame is all zeros.
